// File: rtl/crc_share_arbiter.sv
// crc_share_arbiter: shares one CRC5/CRC16 engine between the RX and TX byte
// processors. One requester owns the engine per packet; the CRC is cleared for
// one cycle before each grant, and only the owner's controls reach the engine.
// Optional hold watchdog: define CRC_ARB_WATCHDOG_EN to bound grant length to
// MAX_HOLD cycles (holdTimeout pulses on a forced release).
//
// Handshake: a requester raises req and holds it for the whole packet. It may
// drive its CRC controls only once it sees gnt=1; gnt stays high until the
// cycle after req is seen low (or the watchdog fires). Enables driven without
// gnt are discarded.
module crc_share_arbiter #(
  parameter int MAX_HOLD = 1023,
  parameter int CNT_W    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxReq,
  output logic       rxGnt,
  input  logic       rxRstCRC,
  input  logic       rxCRC5En,
  input  logic       rxCRC16En,
  input  logic       rxCRC5_8Bit,
  input  logic [7:0] rxCRCData,
  output logic       rxCRC5UpdateRdy,
  output logic       rxCRC16UpdateRdy,
  input  logic       txReq,
  output logic       txGnt,
  input  logic       txRstCRC,
  input  logic       txCRC5En,
  input  logic       txCRC16En,
  input  logic       txCRC5_8Bit,
  input  logic [7:0] txCRCData,
  output logic       txCRC5UpdateRdy,
  output logic       txCRC16UpdateRdy,
  output logic       crcRst,
  output logic       crc5En,
  output logic       crc16En,
  output logic       crc5_8Bit,
  output logic [7:0] crcData,
  input  logic       crc5UpdateRdy,
  input  logic       crc16UpdateRdy,
  output logic       holdTimeout,
  output logic [1:0] o_dbg_state
);

  // The hold counter must be able to represent MAX_HOLD-1.
  if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("crc_share_arbiter: CNT_W too small for MAX_HOLD");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_BUSY = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_owner;        // 0 = RX, 1 = TX
  logic       w_owner_next;
  logic       r_last;         // last owner; resets to TX so RX wins first tie
  logic       r_rx_gnt;
  logic       r_tx_gnt;
  logic       r_timeout;
  logic       w_timeout;
  logic       w_hold_hit;
  logic [1:0] w_armed;        // [0] = RX, [1] = TX
  logic       w_rx_arm;
  logic       w_tx_arm;
  logic       w_own_req;

  assign w_rx_arm  = rxReq & w_armed[0];
  assign w_tx_arm  = txReq & w_armed[1];
  assign w_own_req = r_owner ? txReq : rxReq;

`ifdef CRC_ARB_WATCHDOG_EN
  logic [CNT_W-1:0] r_hold_cnt;
  logic [1:0]       r_armed;

  // Hold counter: zero outside BUSY, counts BUSY cycles, saturates.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_BUSY) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  // Armed bits: cleared by a watchdog release, re-set once req is seen low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 2'b11;
    end else begin
      r_armed[0] <= (w_timeout && !r_owner) ? 1'b0 : (!rxReq ? 1'b1 : r_armed[0]);
      r_armed[1] <= (w_timeout &&  r_owner) ? 1'b0 : (!txReq ? 1'b1 : r_armed[1]);
    end
  end

  assign w_hold_hit = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign w_armed    = r_armed;
`else
  assign w_hold_hit = 1'b0;
  assign w_armed    = 2'b11;
`endif

  // State, owner, last-owner, grant and timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_rx_gnt  <= 1'b0;
      r_tx_gnt  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_owner   <= w_owner_next;
      r_rx_gnt  <= (w_next == S_BUSY) && !w_owner_next;
      r_tx_gnt  <= (w_next == S_BUSY) &&  w_owner_next;
      r_timeout <= w_timeout;
      if (r_state == S_CLR) begin
        r_last <= r_owner;
      end
    end
  end

  // Next-state logic; REL arbitrates like IDLE so a waiting requester is
  // cleared in the cycle right after the release.
  always_comb begin
    w_next       = r_state;
    w_owner_next = r_owner;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE, S_REL: begin
        w_next = S_IDLE;
        if (w_rx_arm && w_tx_arm) begin
          w_owner_next = ~r_last;
          w_next       = S_CLR;
        end else if (w_rx_arm) begin
          w_owner_next = 1'b0;
          w_next       = S_CLR;
        end else if (w_tx_arm) begin
          w_owner_next = 1'b1;
          w_next       = S_CLR;
        end
      end
      S_CLR: begin
        w_next = S_BUSY;
      end
      S_BUSY: begin
        if (!w_own_req) begin
          w_next = S_REL;
        end else if (w_hold_hit) begin
          w_next    = S_REL;
          w_timeout = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Engine mux and ready-strobe routing; only the owner in BUSY is visible.
  always_comb begin
    crcRst           = 1'b0;
    crc5En           = 1'b0;
    crc16En          = 1'b0;
    crc5_8Bit        = 1'b0;
    crcData          = 8'h00;
    rxCRC5UpdateRdy  = 1'b0;
    rxCRC16UpdateRdy = 1'b0;
    txCRC5UpdateRdy  = 1'b0;
    txCRC16UpdateRdy = 1'b0;
    if (r_state == S_CLR) begin
      crcRst = 1'b1;
    end else if (r_state == S_BUSY) begin
      if (r_owner) begin
        crcRst           = txRstCRC;
        crc5En           = txCRC5En;
        crc16En          = txCRC16En;
        crc5_8Bit        = txCRC5_8Bit;
        crcData          = txCRCData;
        txCRC5UpdateRdy  = crc5UpdateRdy;
        txCRC16UpdateRdy = crc16UpdateRdy;
      end else begin
        crcRst           = rxRstCRC;
        crc5En           = rxCRC5En;
        crc16En          = rxCRC16En;
        crc5_8Bit        = rxCRC5_8Bit;
        crcData          = rxCRCData;
        rxCRC5UpdateRdy  = crc5UpdateRdy;
        rxCRC16UpdateRdy = crc16UpdateRdy;
      end
    end
  end

  assign rxGnt       = r_rx_gnt;
  assign txGnt       = r_tx_gnt;
  assign holdTimeout = r_timeout;
  assign o_dbg_state = r_state;

endmodule
